// File: rtl/bus_arbiter_pkg.sv
// Shared arbiter header: bus widths, FSM encoding, timeout counter width.
// Used by bus_arbiter, bus_arbiter_if and bus_timeout_cnt.
package bus_arbiter_pkg;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TO_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_IF  = 2'b01,
      GNT_MEM = 2'b10
   } arb_state_e;

   typedef enum logic {
      LG_IF  = 1'b0,
      LG_MEM = 1'b1
   } arb_mst_e;

   // Grant state that belongs to a master id
   function automatic arb_state_e gnt_of(arb_mst_e m);
      return (m == LG_MEM) ? GNT_MEM : GNT_IF;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Fetch/memory request ports plus the shared bus port.
// slave = arbiter side, master = pipeline and bus-slave side.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rd_data;
   logic          if_busy;
   logic          if_bus_err;

   logic          mem_req;
   logic          mem_rw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] mem_rd_data;
   logic          mem_busy;
   logic          mem_bus_err;

   logic          bus_as;
   logic          bus_rw;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wr_data;
   logic          bus_rdy;
   logic [DW-1:0] bus_rd_data;

   modport slave (
      input  if_req, if_addr,
      output if_rd_data, if_busy, if_bus_err,
      input  mem_req, mem_rw, mem_addr, mem_wr_data,
      output mem_rd_data, mem_busy, mem_bus_err,
      output bus_as, bus_rw, bus_addr, bus_wr_data,
      input  bus_rdy, bus_rd_data
   );

   modport master (
      output if_req, if_addr,
      input  if_rd_data, if_busy, if_bus_err,
      output mem_req, mem_rw, mem_addr, mem_wr_data,
      input  mem_rd_data, mem_busy, mem_bus_err,
      input  bus_as, bus_rw, bus_addr, bus_wr_data,
      output bus_rdy, bus_rd_data
   );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Grant-cycle counter; expire_o flags the last allowed cycle.
// TIMEOUT_CYC must be in 1..255.
module bus_timeout_cnt
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TO_W-1:0] LIM = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Clear has priority over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == LIM);

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter between fetch and memory stages, with timeout.
// BUS_ARB_RR_EN: round-robin on ties; default is fixed MEM-over-IF.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic         clk,
   input  logic         reset,
   bus_arbiter_if.slave bus
);

   arb_state_e    state_q, state_d;
   arb_state_e    idle_pick;
   logic          bus_as_q;
   logic [DW-1:0] if_rd_q, mem_rd_q;
   logic          gnt_if, gnt_mem, in_gnt;
   logic          done, expire, to;
   logic          cnt_clr, cnt_en;
   logic          any_req;

   assign gnt_if  = (state_q == GNT_IF);
   assign gnt_mem = (state_q == GNT_MEM);
   assign in_gnt  = gnt_if | gnt_mem;
   assign done    = in_gnt & bus.bus_rdy;
   assign to      = in_gnt & ~bus.bus_rdy & expire;
   assign cnt_clr = ~in_gnt | done | to;
   assign cnt_en  = in_gnt & ~bus.bus_rdy;
   assign any_req = bus.if_req | bus.mem_req;

`ifdef BUS_ARB_RR_EN
   arb_mst_e lg_q;

   // Tie goes to the master not granted last
   always_comb begin
      idle_pick = bus.mem_req ? GNT_MEM : GNT_IF;
      if (bus.if_req && bus.mem_req)
         idle_pick = (lg_q == LG_MEM) ? gnt_of(LG_IF)
                                      : gnt_of(LG_MEM);
   end
`else
   // Fixed priority: the older instruction (MEM) wins
   always_comb begin
      idle_pick = bus.mem_req ? GNT_MEM : GNT_IF;
   end
`endif

   // Next-state: other master first on completion, abort on timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) state_d = idle_pick;
         end
         GNT_IF: begin
            if (done)
               state_d = bus.mem_req ? GNT_MEM :
                         bus.if_req  ? GNT_IF  : IDLE;
            else if (to)
               state_d = IDLE;
         end
         GNT_MEM: begin
            if (done)
               state_d = bus.if_req  ? GNT_IF  :
                         bus.mem_req ? GNT_MEM : IDLE;
            else if (to)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, address strobe and last-grant tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         bus_as_q <= 1'b0;
`ifdef BUS_ARB_RR_EN
         lg_q     <= LG_IF;
`endif
      end else begin
         state_q  <= state_d;
         bus_as_q <= (state_d != IDLE);
`ifdef BUS_ARB_RR_EN
         if ((state_d != IDLE) && (!in_gnt || done))
            lg_q <= (state_d == GNT_MEM) ? LG_MEM : LG_IF;
`endif
      end
   end

   // Capture read data per master on completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_rd_q  <= '0;
         mem_rd_q <= '0;
      end else begin
         if (gnt_if && bus.bus_rdy)  if_rd_q  <= bus.bus_rd_data;
         if (gnt_mem && bus.bus_rdy) mem_rd_q <= bus.bus_rd_data;
      end
   end

   // Bus fields follow the granted master, zero when idle
   always_comb begin
      bus.bus_rw      = 1'b0;
      bus.bus_addr    = '0;
      bus.bus_wr_data = '0;
      if (gnt_if) begin
         bus.bus_addr    = bus.if_addr;
      end else if (gnt_mem) begin
         bus.bus_rw      = bus.mem_rw;
         bus.bus_addr    = bus.mem_addr;
         bus.bus_wr_data = bus.mem_wr_data;
      end
   end

   assign bus.bus_as = bus_as_q;

   assign bus.if_busy  = bus.if_req
                       & ~(gnt_if & (bus.bus_rdy | expire));
   assign bus.mem_busy = bus.mem_req
                       & ~(gnt_mem & (bus.bus_rdy | expire));

   assign bus.if_bus_err  = gnt_if  & to;
   assign bus.mem_bus_err = gnt_mem & to;

   assign bus.if_rd_data  = (gnt_if && bus.bus_rdy)
                          ? bus.bus_rd_data : if_rd_q;
   assign bus.mem_rd_data = (gnt_mem && bus.bus_rdy)
                          ? bus.bus_rd_data : mem_rd_q;

   bus_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_to (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .expire_o (expire)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT_CYC=4).
// Expectations follow BUS_ARB_RR_EN when defined.
module tb_bus_arbiter;

   logic clk;
   logic reset;
   int   pass;
   int   total;
   logic [31:0] exp_if_rd;
   logic [31:0] exp_mem_rd;

   bus_arbiter_if bif ();

   bus_arbiter #(.TIMEOUT_CYC(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bif.if_req      = 1'b0;
      bif.if_addr     = '0;
      bif.mem_req     = 1'b0;
      bif.mem_rw      = 1'b0;
      bif.mem_addr    = '0;
      bif.mem_wr_data = '0;
      bif.bus_rdy     = 1'b0;
      bif.bus_rd_data = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL rst_as: got %b want 0", bif.bus_as); else pass++;
      total++; if (bif.bus_rw !== 1'b0) $display("FAIL rst_rw: got %b want 0", bif.bus_rw); else pass++;
      total++; if (bif.bus_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bif.bus_addr); else pass++;
      total++; if (bif.bus_wr_data !== 32'h0) $display("FAIL rst_wd: got %h want 0", bif.bus_wr_data); else pass++;
      total++; if (bif.if_rd_data !== 32'h0) $display("FAIL rst_ifrd: got %h want 0", bif.if_rd_data); else pass++;
      total++; if (bif.mem_rd_data !== 32'h0) $display("FAIL rst_memrd: got %h want 0", bif.mem_rd_data); else pass++;
      total++; if ({bif.if_bus_err, bif.mem_bus_err} !== 2'b00) $display("FAIL rst_err: got %b want 00", {bif.if_bus_err, bif.mem_bus_err}); else pass++;
      bif.if_req = 1'b1;
      #1;
      total++; if (bif.if_busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", bif.if_busy); else pass++;
      bif.if_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_if_rd  = 32'h0;
      exp_mem_rd = 32'h0;
   endtask

   task automatic test_idle_rdy();
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'h0000_0BAD;
      #1;
      total++; if (bif.if_rd_data !== exp_if_rd) $display("FAIL idle_ifrd: got %h want %h", bif.if_rd_data, exp_if_rd); else pass++;
      @(negedge clk);
      bif.bus_rdy = 1'b0;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL idle_as: got %b want 0", bif.bus_as); else pass++;
      total++; if (bif.mem_rd_data !== exp_mem_rd) $display("FAIL idle_memrd: got %h want %h", bif.mem_rd_data, exp_mem_rd); else pass++;
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      bif.if_req  = 1'b1;
      bif.if_addr = 32'h100;
      #1;
      total++; if (bif.if_busy !== 1'b1) $display("FAIL sf_busy0: got %b want 1", bif.if_busy); else pass++;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL sf_as0: got %b want 0", bif.bus_as); else pass++;
      @(negedge clk);
      #1;
      total++; if (bif.bus_as !== 1'b1) $display("FAIL sf_as1: got %b want 1", bif.bus_as); else pass++;
      total++; if (bif.bus_addr !== 32'h100) $display("FAIL sf_addr1: got %h want 100", bif.bus_addr); else pass++;
      total++; if (bif.if_busy !== 1'b1) $display("FAIL sf_busy1: got %b want 1", bif.if_busy); else pass++;
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'hDEAD_BEEF;
      #1;
      total++; if (bif.bus_as !== 1'b1) $display("FAIL sf_as2: got %b want 1", bif.bus_as); else pass++;
      total++; if (bif.if_busy !== 1'b0) $display("FAIL sf_busy2: got %b want 0", bif.if_busy); else pass++;
      total++; if (bif.if_rd_data !== 32'hDEAD_BEEF) $display("FAIL sf_rd: got %h want deadbeef", bif.if_rd_data); else pass++;
      bif.if_req = 1'b0;
      exp_if_rd  = 32'hDEAD_BEEF;
      @(negedge clk);
      bif.bus_rdy = 1'b0;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL sf_as3: got %b want 0", bif.bus_as); else pass++;
      total++; if (bif.if_rd_data !== exp_if_rd) $display("FAIL sf_hold: got %h want %h", bif.if_rd_data, exp_if_rd); else pass++;
   endtask

   task automatic test_mem_single();
      @(negedge clk);
      bif.mem_req  = 1'b1;
      bif.mem_rw   = 1'b0;
      bif.mem_addr = 32'h40;
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'h1234_5678;
      #1;
      total++; if (bif.bus_addr !== 32'h40) $display("FAIL ms_addr: got %h want 40", bif.bus_addr); else pass++;
      total++; if (bif.mem_busy !== 1'b0) $display("FAIL ms_busy: got %b want 0", bif.mem_busy); else pass++;
      total++; if (bif.mem_rd_data !== 32'h1234_5678) $display("FAIL ms_rd: got %h want 12345678", bif.mem_rd_data); else pass++;
      total++; if (bif.if_rd_data !== exp_if_rd) $display("FAIL ms_ifrd: got %h want %h", bif.if_rd_data, exp_if_rd); else pass++;
      bif.mem_req = 1'b0;
      exp_mem_rd  = 32'h1234_5678;
      @(negedge clk);
      bif.bus_rdy = 1'b0;
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      bif.if_req      = 1'b1;
      bif.if_addr     = 32'h300;
      bif.mem_req     = 1'b1;
      bif.mem_rw      = 1'b1;
      bif.mem_addr    = 32'h2000;
      bif.mem_wr_data = 32'h55;
      #1;
      total++; if ({bif.if_busy, bif.mem_busy} !== 2'b11) $display("FAIL sim_busy0: got %b want 11", {bif.if_busy, bif.mem_busy}); else pass++;
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'hA5A5_0001;
      #1;
`ifdef BUS_ARB_RR_EN
      total++; if (bif.bus_addr !== 32'h300) $display("FAIL sim_first: got %h want 300", bif.bus_addr); else pass++;
      total++; if ({bif.if_busy, bif.mem_busy} !== 2'b01) $display("FAIL sim_busy1: got %b want 01", {bif.if_busy, bif.mem_busy}); else pass++;
      bif.if_req = 1'b0;
      exp_if_rd  = 32'hA5A5_0001;
`else
      total++; if (bif.bus_addr !== 32'h2000) $display("FAIL sim_first: got %h want 2000", bif.bus_addr); else pass++;
      total++; if (bif.bus_rw !== 1'b1) $display("FAIL sim_rw: got %b want 1", bif.bus_rw); else pass++;
      total++; if (bif.bus_wr_data !== 32'h55) $display("FAIL sim_wd: got %h want 55", bif.bus_wr_data); else pass++;
      total++; if ({bif.if_busy, bif.mem_busy} !== 2'b10) $display("FAIL sim_busy1: got %b want 10", {bif.if_busy, bif.mem_busy}); else pass++;
      bif.mem_req = 1'b0;
      exp_mem_rd  = 32'hA5A5_0001;
`endif
      @(negedge clk);
      bif.bus_rd_data = 32'hA5A5_0002;
      #1;
      total++; if (bif.bus_as !== 1'b1) $display("FAIL sim_b2b_as: got %b want 1", bif.bus_as); else pass++;
`ifdef BUS_ARB_RR_EN
      total++; if (bif.bus_addr !== 32'h2000) $display("FAIL sim_second: got %h want 2000", bif.bus_addr); else pass++;
      total++; if (bif.mem_busy !== 1'b0) $display("FAIL sim_busy2: got %b want 0", bif.mem_busy); else pass++;
      bif.mem_req = 1'b0;
      exp_mem_rd  = 32'hA5A5_0002;
`else
      total++; if (bif.bus_addr !== 32'h300) $display("FAIL sim_second: got %h want 300", bif.bus_addr); else pass++;
      total++; if (bif.bus_rw !== 1'b0) $display("FAIL sim_rw2: got %b want 0", bif.bus_rw); else pass++;
      total++; if (bif.if_busy !== 1'b0) $display("FAIL sim_busy2: got %b want 0", bif.if_busy); else pass++;
      total++; if (bif.if_rd_data !== 32'hA5A5_0002) $display("FAIL sim_ifrd: got %h want a5a50002", bif.if_rd_data); else pass++;
      bif.if_req = 1'b0;
      exp_if_rd  = 32'hA5A5_0002;
`endif
      @(negedge clk);
      bif.bus_rdy = 1'b0;
      bif.mem_rw  = 1'b0;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL sim_end_as: got %b want 0", bif.bus_as); else pass++;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      bif.mem_req  = 1'b1;
      bif.mem_rw   = 1'b0;
      bif.mem_addr = 32'h80;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         #1;
         total++; if ({bif.mem_busy, bif.mem_bus_err} !== 2'b10) $display("FAIL to_cyc%0d: got %b want 10", i, {bif.mem_busy, bif.mem_bus_err}); else pass++;
      end
      @(negedge clk);
      #1;
      total++; if (bif.mem_bus_err !== 1'b1) $display("FAIL to_err: got %b want 1", bif.mem_bus_err); else pass++;
      total++; if (bif.mem_busy !== 1'b0) $display("FAIL to_busy: got %b want 0", bif.mem_busy); else pass++;
      total++; if (bif.mem_rd_data !== exp_mem_rd) $display("FAIL to_rd: got %h want %h", bif.mem_rd_data, exp_mem_rd); else pass++;
      bif.mem_req = 1'b0;
      @(negedge clk);
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL to_idle: got %b want 0", bif.bus_as); else pass++;
      total++; if (bif.mem_bus_err !== 1'b0) $display("FAIL to_pulse: got %b want 0", bif.mem_bus_err); else pass++;
   endtask

   task automatic test_rdy_at_timeout();
      @(negedge clk);
      bif.if_req  = 1'b1;
      bif.if_addr = 32'h500;
      repeat (3) @(negedge clk);
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'hCAFE_F00D;
      #1;
      total++; if (bif.if_bus_err !== 1'b0) $display("FAIL rt_err: got %b want 0", bif.if_bus_err); else pass++;
      total++; if (bif.if_busy !== 1'b0) $display("FAIL rt_busy: got %b want 0", bif.if_busy); else pass++;
      total++; if (bif.if_rd_data !== 32'hCAFE_F00D) $display("FAIL rt_rd: got %h want cafef00d", bif.if_rd_data); else pass++;
      bif.if_req = 1'b0;
      exp_if_rd  = 32'hCAFE_F00D;
      @(negedge clk);
      bif.bus_rdy = 1'b0;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL rt_idle: got %b want 0", bif.bus_as); else pass++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bif.mem_req  = 1'b1;
      bif.mem_addr = 32'h900;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++; if (bif.bus_as !== 1'b1) $display("FAIL rm_as_pre: got %b want 1", bif.bus_as); else pass++;
      reset = 1'b0;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL rm_as_drop: got %b want 0", bif.bus_as); else pass++;
      total++; if (bif.mem_bus_err !== 1'b0) $display("FAIL rm_err: got %b want 0", bif.mem_bus_err); else pass++;
      total++; if (bif.mem_busy !== 1'b1) $display("FAIL rm_busy: got %b want 1", bif.mem_busy); else pass++;
      exp_if_rd  = 32'h0;
      exp_mem_rd = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL rm_idle: got %b want 0", bif.bus_as); else pass++;
      total++; if (bif.if_rd_data !== exp_if_rd) $display("FAIL rm_ifrd: got %h want %h", bif.if_rd_data, exp_if_rd); else pass++;
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'h77;
      #1;
      total++; if (bif.bus_as !== 1'b1) $display("FAIL rm_regnt: got %b want 1", bif.bus_as); else pass++;
      total++; if (bif.bus_addr !== 32'h900) $display("FAIL rm_addr: got %h want 900", bif.bus_addr); else pass++;
      total++; if (bif.mem_rd_data !== 32'h77) $display("FAIL rm_rd: got %h want 77", bif.mem_rd_data); else pass++;
      bif.mem_req = 1'b0;
      exp_mem_rd  = 32'h77;
      @(negedge clk);
      bif.bus_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bif.if_req  = 1'b1;
      bif.if_addr = 32'h600;
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'h1;
      #1;
      total++; if (bif.bus_addr !== 32'h600) $display("FAIL bb_addr0: got %h want 600", bif.bus_addr); else pass++;
      total++; if (bif.if_busy !== 1'b0) $display("FAIL bb_busy0: got %b want 0", bif.if_busy); else pass++;
      bif.if_addr = 32'h604;
      @(negedge clk);
      bif.bus_rdy  = 1'b0;
      bif.mem_req  = 1'b1;
      bif.mem_rw   = 1'b0;
      bif.mem_addr = 32'h700;
      #1;
      total++; if (bif.bus_addr !== 32'h604) $display("FAIL bb_addr1: got %h want 604", bif.bus_addr); else pass++;
      total++; if ({bif.if_busy, bif.mem_busy} !== 2'b11) $display("FAIL bb_busy1: got %b want 11", {bif.if_busy, bif.mem_busy}); else pass++;
      @(negedge clk);
      bif.bus_rdy     = 1'b1;
      bif.bus_rd_data = 32'h2;
      #1;
      total++; if (bif.if_rd_data !== 32'h2) $display("FAIL bb_ifrd: got %h want 2", bif.if_rd_data); else pass++;
      bif.if_addr = 32'h608;
      @(negedge clk);
      bif.bus_rd_data = 32'h3;
      #1;
      total++; if (bif.bus_addr !== 32'h700) $display("FAIL bb_mem: got %h want 700", bif.bus_addr); else pass++;
      total++; if ({bif.if_busy, bif.mem_busy} !== 2'b10) $display("FAIL bb_busy2: got %b want 10", {bif.if_busy, bif.mem_busy}); else pass++;
      total++; if (bif.mem_rd_data !== 32'h3) $display("FAIL bb_memrd: got %h want 3", bif.mem_rd_data); else pass++;
      bif.mem_req = 1'b0;
      @(negedge clk);
      bif.bus_rd_data = 32'h4;
      #1;
      total++; if (bif.bus_addr !== 32'h608) $display("FAIL bb_addr3: got %h want 608", bif.bus_addr); else pass++;
      total++; if (bif.if_rd_data !== 32'h4) $display("FAIL bb_ifrd2: got %h want 4", bif.if_rd_data); else pass++;
      total++; if (bif.mem_rd_data !== 32'h3) $display("FAIL bb_memhold: got %h want 3", bif.mem_rd_data); else pass++;
      bif.if_req = 1'b0;
      @(negedge clk);
      bif.bus_rdy = 1'b0;
      #1;
      total++; if (bif.bus_as !== 1'b0) $display("FAIL bb_idle: got %b want 0", bif.bus_as); else pass++;
   endtask

   initial begin
      pass  = 0;
      total = 0;
      test_reset();
      test_idle_rdy();
      test_single_fetch();
      test_mem_single();
      test_simultaneous();
      test_timeout();
      test_rdy_at_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shared-bus arbiter between the instruction-fetch stage and the memory-access stage. Both stages share a single memory/peripheral bus port. The block grants the bus to one master at a time and sequences each single-word transaction. It generates the `if_busy` / `mem_busy` stall inputs consumed by the pipeline controller, and terminates hung transactions with a timeout error.

## Interface
- `TIMEOUT_CYC`, default 255: cycles in grant without `bus_rdy` before abort; must be 1..255.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, level; held until `if_busy` low.
- `if_addr`  in  32  fetch byte address.
- `if_rd_data`  out  32  fetch read data.
- `if_busy`  out  1  fetch stall.
- `if_bus_err`  out  1  one-cycle pulse: fetch transaction timed out.
- `mem_req`  in  1  load/store request, level.
- `mem_rw`  in  1  1 = write, 0 = read.
- `mem_addr`  in  32  data byte address.
- `mem_wr_data`  in  32  store data.
- `mem_rd_data`  out  32  load data.
- `mem_busy`  out  1  memory-stage stall.
- `mem_bus_err`  out  1  one-cycle pulse: data transaction timed out.
- `bus_as`  out  1  address strobe, high for the whole transaction.
- `bus_rw`, `bus_addr`, `bus_wr_data`  out  1/32/32  muxed from the granted master.
- `bus_rdy`  in  1  slave completion, single-cycle.
- `bus_rd_data`  in  32  slave read data, valid with `bus_rdy`.

## Operation
- States:
  - IDLE.
  - GNT_IF.
  - GNT_MEM.
- IDLE:
  - No request: stay in IDLE.
  - Any request: go to the grant state selected by the arbitration policy (see Configuration).
- GNT_x:
  - `bus_as`=1; bus fields are driven from master x's inputs.
  - On `bus_rdy`=1 the transaction completes. Next state:
    - GNT_y if the other master is requesting (back-to-back, no IDLE bubble).
    - Else GNT_x if x's `req` is still high in the next cycle's arbitration.
    - Else IDLE.
- Busy outputs:
  - `x_busy` = `x_req` & ~(state==GNT_x & `bus_rdy`).
  - Both are combinational. The pipeline controller ORs them into stall.
- Read data:
  - `x_rd_data` = `bus_rd_data` when state==GNT_x & `bus_rdy`; otherwise it holds the last value captured for x.
  - Held values are registered per master.
- Timeout:
  - An 8-bit counter clears on entry to any grant state and increments each grant cycle without `bus_rdy`.
  - At count==TIMEOUT_CYC-1 with no `bus_rdy`:
    - Pulse `x_bus_err` and drop `x_busy` in that cycle.
    - Go to IDLE.
    - Leave `x_rd_data` unchanged.
- Masters hold `req`, `addr`, `rw` and `wr_data` stable while busy. A request dropped in grant does not abort the transaction; the transaction runs to completion or timeout.
- `bus_rdy` in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `bus_as`=0, `bus_rw`=0, `bus_addr`=0, `bus_wr_data`=0.
  - `if_rd_data`=0, `mem_rd_data`=0.
  - Error pulses 0, counter 0, last-grant = IF.
- Busy outputs follow `req` combinationally, including during reset.
- Latency:
  - Request in cycle 0 (IDLE): grant in cycle 1.
  - Earliest completion is cycle 1, with `bus_rdy` in the first grant cycle.
  - Minimum 2 cycles from an idle start; 1 cycle per access back-to-back.
- Simultaneous requests in IDLE: resolved by policy. The loser stays busy and is granted immediately after the winner completes.
- `bus_rdy` and timeout in the same cycle: completion wins, no error.
- Reset asserted mid-transaction: `bus_as` drops asynchronously, state goes to IDLE, no error pulse.

## Configuration
- `BUS_ARB_RR_EN`:
  - Defined: round-robin. On simultaneous requests, grant the master not granted last; last-grant updates on every grant entry.
  - Undefined: fixed priority, MEM over IF, so the older instruction proceeds. Last-grant register is not built.

## Structure
- Address/data widths come from the shared bus header.
- State encoding (IDLE=2'b00, GNT_IF=2'b01, GNT_MEM=2'b10) and the timeout width go in a new shared arbiter header.
- One sub-module, `bus_timeout_cnt`: clear/enable inputs, TIMEOUT_CYC parameter, `expire` output.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x100, `bus_rdy` in the second grant cycle, `bus_rd_data`=0xDEADBEEF.
  - `bus_as` high for 2 cycles, `bus_addr`=0x100.
  - `if_busy` low with `if_rd_data`=0xDEADBEEF in the `bus_rdy` cycle.
- Simultaneous `if_req` and `mem_req` (write, addr 0x2000, data 0x55), `bus_rdy` every grant cycle:
  - Fixed priority: GNT_MEM, then GNT_IF back-to-back.
  - `BUS_ARB_RR_EN` with last grant = MEM: GNT_IF first.
- Timeout with TIMEOUT_CYC=4, `bus_rdy` never asserted:
  - `mem_bus_err` pulses in the 4th grant cycle.
  - `mem_busy` low in that cycle; state IDLE next.
- `bus_rdy` coincident with the final timeout cycle: completes normally, no error.
- Reset pulled low in the 2nd grant cycle: `bus_as`=0 immediately; after release, state IDLE and the pending request is re-granted.
- Continuous `if_req` with `mem_req` raised mid-stream: MEM granted directly after the current fetch completes.
